// File: rtl/feature_stream_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | feature_stream_bridge                                                    |
// | Elastic FIFO bridge from featurizer to DNN: ready/valid output, window   |
// | last marker from a frame counter, clean window truncation on overflow.   |
// | Optional macro FEATURE_BRIDGE_STATS_EN: saturating drop counter.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module feature_stream_bridge #(
  parameter  int FEATURE_BW        = 8,
  parameter  int NUM_CHANNELS      = 13,
  parameter  int FIFO_DEPTH        = 16,
  parameter  int FRAMES_PER_WINDOW = 50,
  localparam int VEC_BW            = FEATURE_BW * NUM_CHANNELS
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic [VEC_BW-1:0] data_i,
  input  logic              valid_i,
  output logic [VEC_BW-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic              overflow_o,
  output logic [15:0]       drop_count_o
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W   = (FRAMES_PER_WINDOW > 1) ? $clog2(FRAMES_PER_WINDOW) : 1;

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(FRAMES_PER_WINDOW - 1);
  localparam logic [FC_W-1:0]   FC_ONE   = FC_W'(1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] tail_ptr;
  logic [FC_W-1:0]   fc;
  logic              overflow;
  logic [VEC_BW:0]   mem [FIFO_DEPTH];
  logic [VEC_BW:0]   head;

  logic push_req;
  logic pop;
  logic push_acc;
  logic drop;
  logic full;
  logic tag_now;
  logic tag_tail;

  assign full     = (state == FULL);
  assign valid_o  = (state != EMPTY);
  assign push_req = valid_i & en_i & ~clear_i;
  assign pop      = valid_o & ready_i & ~clear_i;
  assign push_acc = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign tag_now  = (fc == FC_LAST);
  // Only the first drop of a window closes it; later drops see fc == 0.
  assign tag_tail = drop & (fc != '0);
  assign tail_ptr = wr_ptr - PTR_ONE;

  always_comb begin
    count_next = count;
    state_next = PARTIAL;
    if (clear_i) begin
      count_next = '0;
    end else if (push_acc && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push_acc) begin
      count_next = count - CNT_ONE;
    end
    if (count_next == '0) begin
      state_next = EMPTY;
    end else if (count_next == CNT_FULL) begin
      state_next = FULL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= EMPTY;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fc       <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (clear_i) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fc       <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_acc) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          fc     <= tag_now ? '0 : fc + FC_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (drop) begin
          overflow <= 1'b1;
          fc       <= '0;
        end
      end
    end
  end

  // Storage is not reset: contents are only visible through valid_o.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem[wr_ptr] <= {tag_now, data_i};
    end
    if (tag_tail) begin
      mem[tail_ptr][VEC_BW] <= 1'b1;
    end
  end

  assign head       = mem[rd_ptr];
  assign data_o     = valid_o ? head[VEC_BW-1:0] : '0;
  assign last_o     = valid_o ? head[VEC_BW] : 1'b0;
  assign overflow_o = overflow;

`ifdef FEATURE_BRIDGE_STATS_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt <= 16'h0000;
    end else if (clear_i) begin
      drop_cnt <= 16'h0000;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'h0001;
    end
  end

  assign drop_count_o = drop_cnt;
`else
  assign drop_count_o = 16'h0000;
`endif

endmodule
`default_nettype wire
